// File: rtl/mmio_out_fifo.sv
// Memory-mapped output FIFO on the core's data bus, drained over valid/ready.
// Define MMIO_OUT_FIFO_CYCCNT_EN to add a loadable free-running cycle counter at offset 3.
module mmio_out_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OFF_DATA    = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_CONTROL = 2'd2,
    OFF_CYCCNT  = 2'd3
  } offset_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic          overflow;

  offset_t       offset;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_ovf;
  logic [7:0]    count8;
  logic [31:0]   status;
  logic [31:0]   cyc_value;

  // Byte lane bits of the address are never decoded.
  logic          unused_addr_bits;
  assign unused_addr_bits = &{1'b0, a[1:0]};

  assign sel      = (a[31:4] == BASE_ADDR[31:4]);
  assign offset   = offset_t'(a[3:2]);

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = out_valid & out_ready;
  assign push_req = we & sel & (offset == OFF_DATA);
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);

  assign ctrl_wr  = we & sel & (offset == OFF_CONTROL);
  assign flush    = ctrl_wr & wd[0];
  assign clr_ovf  = ctrl_wr & wd[1];

  // Array storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wd;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping; flush dominates any pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr <= rptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (push_req & full & ~pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef MMIO_OUT_FIFO_CYCCNT_EN
  logic [31:0] cyccnt;

  // A bus load takes effect on the edge; counting resumes from the loaded value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyccnt <= '0;
    end else if (we & sel & (offset == OFF_CYCCNT)) begin
      cyccnt <= wd;
    end else begin
      cyccnt <= cyccnt + 32'd1;
    end
  end

  assign cyc_value = cyccnt;
`else
  assign cyc_value = 32'd0;
`endif

  assign out_valid = ~empty;
  assign out_data  = empty ? 32'd0 : mem[rptr];

  assign count8 = 8'(count);
  assign status = {16'd0, count8, 5'd0, overflow, full, empty};

  // Combinational bus read path, required by the single-cycle core.
  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (offset)
        OFF_DATA:    rd = out_data;
        OFF_STATUS:  rd = status;
        OFF_CONTROL: rd = 32'd0;
        OFF_CYCCNT:  rd = cyc_value;
        default:     rd = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/mmio_out_fifo.md
Name: mmio_out_fifo

Overview:
- Memory-mapped output peripheral on the single-cycle core's data bus, in parallel with data memory.
- Consumes the core's memwrite, dataadr and writedata signals.
- Stores written words into a FIFO and drains them to an external consumer over a valid/ready handshake.
- Supplies readdata combinationally for status reads; the top level selects its rd over dmem's when sel=1.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >=2
BASE_ADDR, 32'h0000_FF00, base byte address of the 16-byte register window; bits [3:0] must be 0

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high
we  input  1  bus write strobe (core memwrite)
a  input  32  bus byte address (core aluout)
wd  input  32  bus write data
rd  output  32  bus read data, combinational
sel  output  1  address hits register window
out_data  output  32  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Address decode: sel = (a[31:4] == BASE_ADDR[31:4]). Offset = a[3:2]; a[1:0] ignored.
- Offset 0, DATA:
  - Write pushes wd.
  - Read returns the head word, or 0 if empty. Reads have no side effect.
- Offset 1, STATUS (read-only; writes ignored):
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - bits[15:8] count, zero-extended.
  - All other bits 0.
- Offset 2, CONTROL:
  - Write bit0=1: flush.
  - Write bit1=1: clear overflow.
  - Read returns 0.
- Offset 3, CYCCNT: see Optional Feature.
- When sel=0: rd=0 and writes have no effect.
- Storage:
  - DEPTH x 32 array, read pointer and write pointer of width log2(DEPTH), count of width clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH.
- Derived signals:
  - full = (count==DEPTH); empty = (count==0).
  - pop = out_valid & out_ready.
  - push_req = we & sel & offset==0.
  - push = push_req & (!full | pop).
- Write/pop/count rules:
  - Push writes the array at wptr and advances wptr on the rising edge.
  - Pop advances rptr.
  - count += push - pop. Push and pop in the same cycle leaves count unchanged.
  - Full with simultaneous push and pop: both are accepted, count stays DEPTH.
  - push_req while full and no pop: word dropped, overflow set to 1 on that edge.
- Flush: rptr=wptr=count=0 on the edge. A flush coinciding with a pop wins (no effect beyond the flush). Array contents are not cleared.
- Overflow clear and overflow set in the same cycle cannot occur (single write port).
- Outputs:
  - out_valid = !empty.
  - out_data = array[rptr] when non-empty, else 0.
  - out_data and out_valid change only on clk edges or reset.
- Handshake:
  - Once out_valid=1, the head stays stable until popped or flushed.
  - out_ready may be asserted with out_valid=0; no effect.
- Reset values: rptr, wptr, count, overflow = 0, so out_valid=0 and out_data=0.
  - Reset mid-stream discards all entries immediately (asynchronous).
  - rd follows the reset state combinationally.
- Latency:
  - A word written at edge N is visible on out_data/out_valid after edge N.
  - Bus read data is combinational, as required by the single-cycle core.
- Writes to the DATA offset are full-word; there are no byte enables.

Optional Feature:
- Macro: MMIO_OUT_FIFO_CYCCNT_EN.
- Defined:
  - 32-bit free-running cycle counter at offset 3, reset to 0, incrementing every clk and wrapping 32'hFFFF_FFFF -> 0.
  - A write at offset 3 loads wd; the counter then increments from that value on the next edge.
  - A read returns the current value.
- Not defined: offset 3 reads 0, writes are ignored, and no counter flops exist.

Test Plan:
- Reset, then read STATUS (a=32'hFF04) -> rd=32'h0000_0001; out_valid=0; out_data=0.
- Write 7, 28, 5 to 32'hFF00 with out_ready=0:
  - STATUS count=3; out_data=7.
  - Raise out_ready for 3 cycles -> out_data sequence 7, 28, 5; then out_valid=0, STATUS=32'h0000_0001.
- Fill 8 words (1..8) with out_ready=0 -> STATUS=32'h0000_0802.
  - 9th write of 99 -> dropped, STATUS=32'h0000_0806.
  - Write 32'h2 to 32'hFF08 -> STATUS=32'h0000_0802.
- Full FIFO, out_ready=1, write 42 in the same cycle -> head 1 popped, 42 accepted, count remains 8; drain order 2..8, 42.
- Write 3 words, then write 32'h1 to 32'hFF08 while out_ready=1 -> count=0, out_valid=0, no overflow.
  - Assert reset asynchronously mid-fill -> out_valid drops to 0 before the next clk edge.
- With MMIO_OUT_FIFO_CYCCNT_EN defined:
  - Write 32'hFFFF_FFFE to 32'hFF0C, then read on each of the next three cycles -> FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - Without the macro, the same read returns 0.
- Write to 32'h0000_0040 (sel=0) -> FIFO unchanged, rd=0.
